// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the data port (load/store),
// instruction fetch and an external DMA/debug port. One transaction is
// in flight at a time. Priority is data > fetch > DMA, except that DMA
// jumps to the top once it has been passed over STARVE_LIMIT times.
// A memory that never acks is abandoned after TIMEOUT busy cycles and
// the requester receives an ack with rsp_err set.
//
// Ports:
//   clk, reset (async, active low)
//   d_*       data requester   (req/we/addr/wdata in, ack out)
//   if_*      fetch requester  (req/addr in, ack out; always a read)
//   dma_*     DMA requester    (req/we/addr/wdata in, ack out)
//   rsp_*     response data/error, valid while any ack is high
//   mem_*     memory port      (req/we/addr/wdata out, ack/rdata in)
//   busy      high while a transaction occupies the memory (BUSY, DONE)
//   grant_id  current owner: 00 none, 01 data, 10 fetch, 11 DMA
//
// state | meaning
// IDLE  | no owner; arbitrate any pending requests
// BUSY  | mem_req held to memory, waiting for mem_ack or timeout
// DONE  | one-cycle ack to the owner, response valid
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] GID_NONE  = 2'b00;
    localparam logic [1:0] GID_DATA  = 2'b01;
    localparam logic [1:0] GID_FETCH = 2'b10;
    localparam logic [1:0] GID_DMA   = 2'b11;

    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state, state_nxt;
    logic [7:0]        wait_cnt, wait_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic [1:0]        winner;
    logic [1:0]        grant_nxt;
    logic              mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic              rsp_err_nxt;
    logic              d_ack_nxt, if_ack_nxt, dma_ack_nxt;
    logic              busy_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            grant_id   <= GID_NONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            d_ack      <= 1'b0;
            if_ack     <= 1'b0;
            dma_ack    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            starve_cnt <= starve_nxt;
            grant_id   <= grant_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            rsp_rdata  <= rsp_rdata_nxt;
            rsp_err    <= rsp_err_nxt;
            d_ack      <= d_ack_nxt;
            if_ack     <= if_ack_nxt;
            dma_ack    <= dma_ack_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        // A starved DMA requester outranks even the data port.
        winner = GID_NONE;
        if (dma_req && (starve_cnt == STARVE_MAX)) winner = GID_DMA;
        else if (d_req)                            winner = GID_DATA;
        else if (if_req)                           winner = GID_FETCH;
        else if (dma_req)                          winner = GID_DMA;
    end

    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        starve_nxt    = dma_req ? starve_cnt : 4'd0;
        grant_nxt     = grant_id;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        d_ack_nxt     = 1'b0;
        if_ack_nxt    = 1'b0;
        dma_ack_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (winner != GID_NONE) begin
                    state_nxt   = BUSY;
                    grant_nxt   = winner;
                    mem_req_nxt = 1'b1;
                    wait_nxt    = 8'd0;
                    if (winner == GID_DMA)
                        starve_nxt = 4'd0;
                    else if (dma_req && (starve_cnt != STARVE_MAX))
                        starve_nxt = starve_cnt + 4'd1;
                    unique case (winner)
                        GID_DATA: begin
                            mem_we_nxt    = d_we;
                            mem_addr_nxt  = d_addr;
                            mem_wdata_nxt = d_wdata;
                        end
                        GID_FETCH: begin
                            mem_we_nxt    = 1'b0;
                            mem_addr_nxt  = if_addr;
                            mem_wdata_nxt = '0;
                        end
                        default: begin
                            mem_we_nxt    = dma_we;
                            mem_addr_nxt  = dma_addr;
                            mem_wdata_nxt = dma_wdata;
                        end
                    endcase
                end
            end
            BUSY: begin
                // mem_ack is checked first so it wins over a same-cycle timeout.
                if (mem_ack || (wait_cnt == WAIT_LAST)) begin
                    state_nxt     = DONE;
                    mem_req_nxt   = 1'b0;
                    mem_we_nxt    = 1'b0;
                    rsp_err_nxt   = !mem_ack;
                    rsp_rdata_nxt = (mem_ack && !mem_we) ? mem_rdata : '0;
                    d_ack_nxt     = (grant_id == GID_DATA);
                    if_ack_nxt    = (grant_id == GID_FETCH);
                    dma_ack_nxt   = (grant_id == GID_DMA);
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            DONE: begin
                state_nxt     = IDLE;
                grant_nxt     = GID_NONE;
                rsp_rdata_nxt = '0;
                rsp_err_nxt   = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = GID_NONE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port unified memory of the multicycle CPU between three requesters: data access (load/store from MEMORY state), instruction fetch (FETCH state) and an external DMA/debug port. One transaction is in flight at a time. Data has fixed top priority, fetch is second and DMA is last, with an anti-starvation promotion for DMA. A bounded-wait timeout returns an error instead of hanging the control FSM.

Parameters:
ADDR_W, 16, address width for all requesters and the memory port
DATA_W, 32, data width
TIMEOUT, 16, maximum BUSY cycles waiting for mem_ack before abort; legal range 2..255
STARVE_LIMIT, 4, number of grants to other requesters while DMA waits before DMA is promoted to top priority; legal range 1..15

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
d_req  in  1  data request; held until d_ack
d_we  in  1  data write (1) / read (0)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  data write data
d_ack  out  1  one-cycle completion pulse to data requester
if_req  in  1  fetch request (always a read); held until if_ack
if_addr  in  ADDR_W  fetch address (PC)
if_ack  out  1  one-cycle completion pulse to fetch
dma_req  in  1  DMA request; held until dma_ack
dma_we  in  1  DMA write/read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_ack  out  1  one-cycle completion pulse to DMA
rsp_rdata  out  DATA_W  read data; valid only while any ack is high
rsp_err  out  1  timeout flag; valid only while any ack is high
mem_req  out  1  memory request; held until mem_ack or timeout
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion; mem_rdata valid with it on reads
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in BUSY and DONE
grant_id  out  2  current owner: 00 none, 01 data, 10 fetch, 11 DMA

Behaviour:
- All outputs are registered. While reset is low, everything is 0, state is IDLE and both counters are 0. mem_req drops asynchronously when reset asserts.
- FSM states:
  - IDLE: if any request is high, choose a winner, latch grant_id, latch address/we/wdata into the mem_* registers, set mem_req=1 and go to BUSY. Otherwise stay in IDLE.
  - BUSY: mem_* outputs are held stable. On a cycle where mem_ack=1: capture mem_rdata into rsp_rdata (0 for writes), set rsp_err=0, drop mem_req, go to DONE. If the wait counter reaches TIMEOUT-1 with no mem_ack: drop mem_req, set rsp_rdata=0 and rsp_err=1, go to DONE.
  - DONE: exactly one ack, selected by grant_id, is high for this one cycle. Next state is IDLE, and grant_id returns to 00 there.
- Wait counter: cleared on entry to BUSY and incremented each BUSY cycle. It is 8 bits wide.
- Priority: data > fetch > DMA. If the starve counter equals STARVE_LIMIT, DMA has top priority for that arbitration.
- Starve counter: increments when a non-DMA grant is made while dma_req=1. It clears on a DMA grant or whenever dma_req=0, and saturates at STARVE_LIMIT.
- Latency: a request that is high in IDLE cycle 0 gets mem_req in cycle 1. With mem_ack in cycle 1, ack is high in cycle 2 and the FSM is back in IDLE in cycle 3. The minimum is 3 cycles per transaction.
- Requester handshake: each requester deasserts req on the edge that ends its ack cycle, so the same request is never re-granted. Once granted, a transaction always completes; if req drops early, the ack is still pulsed.
- mem_ack while not in BUSY is ignored. Requests arriving during BUSY/DONE wait and are arbitrated in the next IDLE.
- Simultaneous mem_ack and timeout in the same cycle: mem_ack wins and rsp_err=0.
- Reset mid-transaction: the transaction is dropped, no ack is issued and both counters clear.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0010, mem_ack in the first BUSY cycle with mem_rdata=0xDEADBEEF -> mem_req high cycle 1, if_ack plus rsp_rdata=0xDEADBEEF and rsp_err=0 in cycle 2, grant_id=10 in cycles 1-2.
- Collision: d_req (write, 0x0100, 0x12345678) and if_req high together -> data is served first (mem_we=1, mem_wdata=0x12345678), d_ack pulses, then fetch is granted in the next IDLE.
- Starvation: dma_req held with fetch re-requesting continuously (STARVE_LIMIT=4) -> 4 fetch grants, then a DMA grant even though if_req=1; the starve counter then reads 0.
- Timeout: memory never acks, TIMEOUT=16 -> mem_req high for exactly 16 cycles, then d_ack with rsp_err=1 and rsp_rdata=0.
- Wait states: mem_ack delayed 5 cycles -> mem_addr/mem_we/mem_wdata stable throughout BUSY, a single ack pulse, a stray mem_ack in IDLE is ignored, and mem_ack coinciding with the timeout cycle gives rsp_err=0.
- Reset in BUSY: reset low mid-wait -> mem_req=0 immediately, no ack, grant_id=00; the first request after release is served normally.
